dcache_sram_nway: RTL and testbench
===================================

// Module: dcache_sram_nway
// PURPOSE
//   Parametrised N-way set-associative tag/data store for the L1 data cache.
//   Generalises the fixed 16-set, 2-way store: configurable sets, ways, tag and line width,
//   true-LRU replacement updated on read and write hits, and a multi-cycle invalidate sweep.
//   Sits between dcache_controller and the data memory interface; the controller drives
//   lookups and fills, and uses tag_o/data_o on a miss for dirty write-back.
// PARAMETERS
//   NUM_SETS  16   number of sets, power of two >= 2; IDX_W = $clog2(NUM_SETS)
//   NUM_WAYS  4    associativity, power of two >= 2; WAY_W = $clog2(NUM_WAYS)
//   TAG_W     23   stored address-tag width
//   LINE_W    256  cache line width in bits
// PORTS
//   clk_i      in   1         clock, all state updates on rising edge
//   rst_n_i    in   1         synchronous active-low reset
//   addr_i     in   IDX_W     set index
//   tag_i      in   TAG_W     lookup / fill tag
//   data_i     in   LINE_W    write / fill line data
//   dirty_i    in   1         dirty value stored on write (1 = CPU write, 0 = fill from memory)
//   enable_i   in   1         access valid this cycle
//   write_i    in   1         1 = write/fill, 0 = read lookup
//   inv_i      in   1         start full invalidate sweep (pulse)
//   tag_o      out  TAG_W+2   {valid, dirty, tag} of hit way, else of victim way
//   data_o     out  LINE_W    line of hit way, else of victim way
//   hit_o      out  1         lookup hit
//   way_o      out  WAY_W     hit way index, else victim way index
//   busy_o     out  1         invalidate sweep in progress
// BEHAVIOUR
//   - Reset (rst_n_i=0 at edge): all valid/dirty/tag/data cleared to 0; LRU ages of every set
//     loaded with age[w] = NUM_WAYS-1-w; FSM -> IDLE; busy_o=0. Reset mid-sweep aborts it.
//   - Outputs are combinational from addr_i/tag_i and current state (zero read latency).
//     enable_i=0 or busy_o=1: tag_o, data_o, hit_o, way_o all 0.
//   - Hit in way w: valid[w] && tag[w]==tag_i. At most one way hits (controller invariant);
//     if several do, lowest index wins.
//   - Victim: lowest-index invalid way if any, else way with age == NUM_WAYS-1.
//   - LRU: per-set ages are a permutation of 0..NUM_WAYS-1. On access to way a:
//     ages < age[a] increment, age[a] <= 0, others unchanged. Updated at edge on
//     read hit, write hit and write miss (fill). Read miss: no state change.
//   - Write (enable_i & write_i, IDLE): target = hit way else victim; tag <= tag_i,
//     valid <= 1, dirty <= dirty_i, data <= data_i; LRU touch target.
//   - FSM IDLE/SWEEP. IDLE & inv_i: -> SWEEP, counter <= 0; any access in that cycle
//     is dropped (inv_i has priority). SWEEP: each cycle clears valid/dirty of set counter
//     and reloads its LRU ages to reset pattern; counter == NUM_SETS-1 -> IDLE.
//     busy_o=1 exactly NUM_SETS cycles. inv_i during SWEEP ignored; data not cleared.
//   - Index wrap: counter width IDX_W, no out-of-range sets exist.
// TESTING
//   1. After reset, read set 3 tag 0x1234 -> hit_o=0, way_o=0, tag_o=0, busy_o=0.
//   2. Fill set 5 tags A,B,C,D (dirty_i=0), read A -> hit_o=1 way_o=0; fill E -> replaces B
//      (way 1); read B -> hit_o=0.
//   3. Write hit set 5 tag A, dirty_i=1, data 0xAA..AA -> next read A: tag_o={1,1,A}, data 0xAA..AA;
//      then miss with A as victim exposes dirty tag/data for write-back.
//   4. NUM_WAYS=2 build: alternate read hits on way 0 while filling -> way 1 always evicted.
//   5. inv_i pulse with simultaneous write -> write dropped; busy_o=1 for 16 cycles;
//      all lookups miss afterwards, LRU back to reset pattern.
//   6. Assert rst_n_i at sweep cycle 7 -> next cycle busy_o=0, all sets invalid, IDLE.

Source files
------------

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway_if: lookup/fill/invalidate bus between dcache_controller and the tag/data store
interface dcache_sram_nway_if #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256
);
  logic [$clog2(NUM_SETS)-1:0] addr_i;
  logic [TAG_W-1:0]            tag_i;
  logic [LINE_W-1:0]           data_i;
  logic                        dirty_i;
  logic                        enable_i;
  logic                        write_i;
  logic                        inv_i;
  logic [TAG_W+1:0]            tag_o;
  logic [LINE_W-1:0]           data_o;
  logic                        hit_o;
  logic [$clog2(NUM_WAYS)-1:0] way_o;
  logic                        busy_o;
  modport master (output addr_i, tag_i, data_i, dirty_i, enable_i, write_i, inv_i,
                  input tag_o, data_o, hit_o, way_o, busy_o);
  modport slave  (input addr_i, tag_i, data_i, dirty_i, enable_i, write_i, inv_i,
                  output tag_o, data_o, hit_o, way_o, busy_o);
endinterface

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative tag/data store with true-LRU and invalidate sweep
module dcache_sram_nway #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 23,
  parameter int LINE_W   = 256
) (
  input logic clk_i,
  input logic rst_n_i,
  dcache_sram_nway_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic valid_q [NUM_SETS][NUM_WAYS];
  logic dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] age_q [NUM_SETS][NUM_WAYS];
  logic hit, any_inv, busy, act, wr, touch;
  logic [WAY_W-1:0] hit_way, inv_way, old_way, tgt;
  // descending scan so the lowest matching/invalid way is the one that sticks
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[bus.addr_i][w] && tag_q[bus.addr_i][w] == bus.tag_i) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[bus.addr_i][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[bus.addr_i][w] == WAY_W'(NUM_WAYS - 1)) old_way = WAY_W'(w);
    end
  end
  assign tgt   = hit ? hit_way : any_inv ? inv_way : old_way;
  assign busy  = state_q == SWEEP;
  assign act   = bus.enable_i && !busy;
  assign wr    = act && bus.write_i && !bus.inv_i;
  assign touch = act && !bus.inv_i && (bus.write_i || hit);
  assign bus.hit_o  = act && hit;
  assign bus.way_o  = act ? tgt : '0;
  assign bus.tag_o  = act ? {valid_q[bus.addr_i][tgt], dirty_q[bus.addr_i][tgt], tag_q[bus.addr_i][tgt]} : '0;
  assign bus.data_o = act ? data_q[bus.addr_i][tgt] : '0;
  assign bus.busy_o = busy;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && bus.inv_i) begin
      state_d = SWEEP;
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == IDX_W'(NUM_SETS - 1) ? IDLE : SWEEP;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w] <= '0;
          data_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(NUM_WAYS - 1 - w);
        end
    end else if (busy) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[cnt_q][w] <= 1'b0;
        dirty_q[cnt_q][w] <= 1'b0;
        age_q[cnt_q][w] <= WAY_W'(NUM_WAYS - 1 - w);
      end
    end else begin
      if (wr) begin
        valid_q[bus.addr_i][tgt] <= 1'b1;
        dirty_q[bus.addr_i][tgt] <= bus.dirty_i;
        tag_q[bus.addr_i][tgt] <= bus.tag_i;
        data_q[bus.addr_i][tgt] <= bus.data_i;
      end
      if (touch) begin
        for (int w = 0; w < NUM_WAYS; w++)
          if (age_q[bus.addr_i][w] < age_q[bus.addr_i][tgt]) age_q[bus.addr_i][w] <= age_q[bus.addr_i][w] + 1'b1;
        age_q[bus.addr_i][tgt] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb_dcache_sram_nway: directed stimulus checked against an MRU-ordered list model every cycle
module tb_dcache_sram_nway;
  localparam int S = 16, W = 4, TW = 23, LW = 256;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dcache_sram_nway_if #(.NUM_SETS(S), .NUM_WAYS(W), .TAG_W(TW), .LINE_W(LW)) bus ();
  dcache_sram_nway #(.NUM_SETS(S), .NUM_WAYS(W), .TAG_W(TW), .LINE_W(LW)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  dcache_sram_nway_if #(.NUM_SETS(S), .NUM_WAYS(2), .TAG_W(TW), .LINE_W(LW)) bus2 ();
  dcache_sram_nway #(.NUM_SETS(S), .NUM_WAYS(2), .TAG_W(TW), .LINE_W(LW)) dut2 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus2));
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // model: per-set list of ways ordered most- to least-recently used
  bit mv [S][W], md [S][W];
  logic [TW-1:0] mt [S][W];
  logic [LW-1:0] mdat [S][W];
  int ord [S][W];
  bit mbusy = 0, armed = 0;
  int mcnt = 0, mh, mtg, ch, cw;
  function automatic void reset_ord(int s);
    for (int p = 0; p < W; p++) ord[s][p] = W - 1 - p;
  endfunction
  function automatic void use_way(int s, int w);
    int p = 0;
    for (int i = 0; i < W; i++) if (ord[s][i] == w) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = w;
  endfunction
  function automatic int find_hit(int s, logic [TW-1:0] t);
    for (int w = 0; w < W; w++) if (mv[s][w] && mt[s][w] == t) return w;
    return -1;
  endfunction
  function automatic int victim(int s);
    for (int w = 0; w < W; w++) if (!mv[s][w]) return w;
    return ord[s][W-1];
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      armed = 1;
      mbusy = 0;
      mcnt = 0;
      for (int s = 0; s < S; s++) begin
        for (int w = 0; w < W; w++) begin
          mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0; mdat[s][w] = '0;
        end
        reset_ord(s);
      end
    end else if (mbusy) begin
      for (int w = 0; w < W; w++) begin
        mv[mcnt][w] = 0; md[mcnt][w] = 0;
      end
      reset_ord(mcnt);
      if (mcnt == S - 1) mbusy = 0;
      mcnt = (mcnt + 1) % S;
    end else if (bus.inv_i) begin
      mbusy = 1;
      mcnt = 0;
    end else if (bus.enable_i) begin
      mh = find_hit(int'(bus.addr_i), bus.tag_i);
      mtg = mh >= 0 ? mh : victim(int'(bus.addr_i));
      if (bus.write_i) begin
        mv[bus.addr_i][mtg] = 1;
        md[bus.addr_i][mtg] = bus.dirty_i;
        mt[bus.addr_i][mtg] = bus.tag_i;
        mdat[bus.addr_i][mtg] = bus.data_i;
        use_way(int'(bus.addr_i), mtg);
      end else if (mh >= 0) use_way(int'(bus.addr_i), mh);
    end
  end
  always @(negedge clk) if (armed) begin
    chk("busy", bus.busy_o, mbusy);
    if (!bus.enable_i || mbusy) begin
      chk("hit_idle", bus.hit_o, 0);
      chk("way_idle", bus.way_o, 0);
      chk("tag_idle", bus.tag_o, 0);
      chk("data_idle", bus.data_o, 0);
    end else begin
      ch = find_hit(int'(bus.addr_i), bus.tag_i);
      cw = ch >= 0 ? ch : victim(int'(bus.addr_i));
      chk("hit", bus.hit_o, ch >= 0);
      chk("way", bus.way_o, cw);
      chk("tag", bus.tag_o, {mv[bus.addr_i][cw], md[bus.addr_i][cw], mt[bus.addr_i][cw]});
      chk("data", bus.data_o, mdat[bus.addr_i][cw]);
    end
  end
  task automatic put(bit en, bit wr, int s, logic [TW-1:0] t, logic [LW-1:0] d, bit dt, bit inv);
    bus.enable_i = en; bus.write_i = wr; bus.addr_i = 4'(s); bus.tag_i = t;
    bus.data_i = d; bus.dirty_i = dt; bus.inv_i = inv;
    #1;
  endtask
  task automatic put2(bit en, bit wr, int s, logic [TW-1:0] t);
    bus2.enable_i = en; bus2.write_i = wr; bus2.addr_i = 4'(s); bus2.tag_i = t;
    bus2.data_i = {8{t[7:0]}}; bus2.dirty_i = 0; bus2.inv_i = 0;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  logic [TW-1:0] tg [5];
  logic [LW-1:0] aa;
  int n;
  initial begin
    tg[0] = 23'h0A0A0A; tg[1] = 23'h0B0B0B; tg[2] = 23'h0C0C0C; tg[3] = 23'h0D0D0D; tg[4] = 23'h0E0E0E;
    aa = {32{8'hAA}};
    put(0, 0, 0, '0, '0, 0, 0);
    put2(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    put(1, 0, 3, 23'h1234, '0, 0, 0);
    chk("t1_hit", bus.hit_o, 0); chk("t1_way", bus.way_o, 0);
    chk("t1_tag", bus.tag_o, 0); chk("t1_busy", bus.busy_o, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      put(1, 1, 5, tg[i], LW'(i + 1), 0, 0);
      chk("t2_fill_way", bus.way_o, i);
      tick();
    end
    put(1, 0, 5, tg[0], '0, 0, 0);
    chk("t2_readA_hit", bus.hit_o, 1); chk("t2_readA_way", bus.way_o, 0);
    tick();
    put(1, 1, 5, tg[4], LW'(5), 0, 0);
    chk("t2_fillE_hit", bus.hit_o, 0); chk("t2_fillE_way", bus.way_o, 1);
    chk("t2_fillE_victim", bus.tag_o, {2'b10, tg[1]});
    tick();
    put(1, 0, 5, tg[1], '0, 0, 0);
    chk("t2_readB_hit", bus.hit_o, 0);
    tick();
    put(1, 0, 5, tg[4], '0, 0, 0);
    chk("t2_readE_way", bus.way_o, 1); chk("t2_readE_data", bus.data_o, LW'(5));
    tick();
    put(1, 1, 5, tg[0], aa, 1, 0);
    chk("t3_wr_hit", bus.hit_o, 1);
    tick();
    put(1, 0, 5, tg[0], '0, 0, 0);
    chk("t3_tag", bus.tag_o, {2'b11, tg[0]}); chk("t3_data", bus.data_o, aa);
    tick();
    for (int i = 4; i >= 2; i -= 1) begin
      put(1, 0, 5, tg[i == 4 ? 4 : 5 - i], '0, 0, 0);
      tick();
    end
    put(1, 0, 5, 23'h0F0F0F, '0, 0, 0);
    chk("t3_miss_hit", bus.hit_o, 0); chk("t3_miss_way", bus.way_o, 0);
    chk("t3_wb_tag", bus.tag_o, {2'b11, tg[0]}); chk("t3_wb_data", bus.data_o, aa);
    tick();
    put(1, 1, 3, 23'h777, LW'(7), 1, 0);
    tick();
    put(1, 1, 5, 23'h5555, LW'(9), 0, 1);
    tick();
    put(0, 0, 0, '0, '0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy_o) n++;
      bus.inv_i = (i == 3);
      tick();
    end
    bus.inv_i = 0;
    chk("t5_busy_cycles", n, 16);
    for (int i = 0; i < 5; i++) begin
      put(1, 0, 5, tg[i], '0, 0, 0);
      chk("t5_miss", bus.hit_o, 0); chk("t5_miss_way", bus.way_o, 0);
      tick();
    end
    put(1, 0, 5, 23'h5555, '0, 0, 0);
    chk("t5_dropped_write", bus.hit_o, 0);
    tick();
    put(1, 0, 3, 23'h777, '0, 0, 0);
    chk("t5_set3_miss", bus.hit_o, 0); chk("t5_set3_tag", bus.tag_o, {2'b00, 23'h777});
    tick();
    put(0, 0, 0, '0, '0, 0, 0);
    put2(1, 1, 2, 23'h100); chk("t4_fillX", bus2.way_o, 0); tick();
    put2(1, 1, 2, 23'h200); chk("t4_fillY", bus2.way_o, 1); tick();
    for (int i = 0; i < 4; i++) begin
      put2(1, 0, 2, 23'h100);
      chk("t4_readX_hit", bus2.hit_o, 1); chk("t4_readX_way", bus2.way_o, 0);
      tick();
      put2(1, 1, 2, 23'h300 + 23'(i));
      chk("t4_fill_hit", bus2.hit_o, 0); chk("t4_fill_way", bus2.way_o, 1);
      tick();
    end
    put2(0, 0, 0, '0);
    put(1, 1, 7, 23'h42, LW'(3), 1, 0);
    tick();
    put(0, 0, 0, '0, '0, 0, 1);
    tick();
    put(0, 0, 0, '0, '0, 0, 0);
    repeat (7) tick();
    chk("t6_busy_before", bus.busy_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_busy_after", bus.busy_o, 0);
    put(1, 0, 7, 23'h42, '0, 0, 0);
    chk("t6_set7_miss", bus.hit_o, 0); chk("t6_set7_tag", bus.tag_o, 0);
    tick();
    put(1, 1, 7, 23'h42, LW'(4), 0, 0);
    chk("t6_refill_way", bus.way_o, 0);
    tick();
    put(1, 0, 7, 23'h42, '0, 0, 0);
    chk("t6_reread_hit", bus.hit_o, 1); chk("t6_reread_data", bus.data_o, LW'(4));
    tick();
    put(0, 0, 0, '0, '0, 0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
